// File: rtl/lag_scan_sequencer_pkg.sv
// Shared encodings for the lag/sampling-period sweep sequencer.
package lag_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_WRAP     = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/lag_scan_channel.sv
// One sweep channel: start/increment/len stepping with end-of-sweep handling
// and optional coarse/fine counting where the fine field wraps at DELAY_SIZE.
module lag_scan_channel
  import lag_scan_sequencer_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int FINE_BITS   = 12,
  parameter int SPLIT       = 0,
  parameter int DELAY_SIZE  = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   intclk_i,
  input  logic                   rst_ni,
  input  logic                   active_i,
  input  logic                   step_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH-1:0]       start_i,
  input  logic [WIDTH-1:0]       increment_i,
  input  logic [WIDTH-1:0]       len_i,
  output logic [WIDTH-1:0]       current_o,
  output logic                   done_o,
  output logic                   wrap_pulse_o,
  output logic [COUNT_WIDTH-1:0] sweep_count_o
);

  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0] DELAY_W  = W1'(DELAY_SIZE);
  localparam logic [W1-1:0] FINE_ONE = W1'(1) << FINE_BITS;

  logic [WIDTH-1:0]       current_q, current_d;
  logic                   done_q, done_d;
  logic                   pulse_q, pulse_d;
  dir_e                   dir_q, dir_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [W1-1:0] cur_w, start_w, inc_w, end_w, up_w, dn_w, fine_w;
  logic          up_ok, dn_ok, degen, ev;

  // Candidate neighbours of current, kept one bit wider so the limit tests never wrap.
  always_comb begin
    cur_w   = {1'b0, current_q};
    start_w = {1'b0, start_i};
    inc_w   = {1'b0, increment_i};
    end_w   = start_w + {1'b0, len_i};
    up_w    = cur_w + inc_w;
    dn_w    = cur_w - inc_w;
    fine_w  = W1'(current_q[FINE_BITS-1:0]);
    if (SPLIT != 0) begin
      if ((fine_w + inc_w) >= DELAY_W) up_w = up_w - DELAY_W + FINE_ONE;
      if (fine_w < inc_w)              dn_w = dn_w + DELAY_W - FINE_ONE;
    end
    up_ok = (up_w <= end_w);
    dn_ok = ($signed(dn_w) >= $signed(start_w));
    degen = (increment_i == '0) || (len_i == '0);
  end

  always_comb begin
    current_d = current_q;
    done_d    = done_q;
    dir_d     = dir_q;
    ev        = 1'b0;
    if (!active_i) begin
      current_d = start_i;
      done_d    = 1'b0;
      dir_d     = DIR_UP;
    end else if (step_i) begin
      case (mode_e'(mode_i))
        MODE_HOLD: ;
        MODE_SINGLE: begin
          if (!done_q) begin
            if (!degen && up_ok) current_d = up_w[WIDTH-1:0];
            else begin
              done_d = 1'b1;
              ev     = 1'b1;
            end
          end
        end
        MODE_WRAP: begin
          if (!degen && up_ok) current_d = up_w[WIDTH-1:0];
          else begin
            current_d = start_i;
            ev        = 1'b1;
          end
        end
        MODE_PINGPONG: begin
          if (degen) ev = 1'b1;
          else if (dir_q == DIR_UP) begin
            if (up_ok) current_d = up_w[WIDTH-1:0];
            else begin
              dir_d     = DIR_DOWN;
              current_d = dn_ok ? dn_w[WIDTH-1:0] : start_i;
              ev        = 1'b1;
            end
          end else begin
            if (dn_ok) current_d = dn_w[WIDTH-1:0];
            else begin
              dir_d     = DIR_UP;
              current_d = up_ok ? up_w[WIDTH-1:0] : end_w[WIDTH-1:0];
              ev        = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    pulse_d = ev;
    if (!active_i)            count_d = '0;
    else if (ev && !(&count_q)) count_d = count_q + COUNT_WIDTH'(1);
    else                      count_d = count_q;
  end

  always_ff @(posedge intclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      current_q <= '0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
      dir_q     <= DIR_UP;
      count_q   <= '0;
    end else begin
      current_q <= current_d;
      done_q    <= done_d;
      pulse_q   <= pulse_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
    end
  end

  assign current_o     = current_q;
  assign done_o        = done_q;
  assign wrap_pulse_o  = pulse_q;
  assign sweep_count_o = count_q;

endmodule

// File: rtl/lag_scan_sequencer.sv
// Multi-channel lag sweep generator feeding the per-input CLK_GEN divisors.
module lag_scan_sequencer
  import lag_scan_sequencer_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int WIDTH       = 24,
  parameter int FINE_BITS   = 12,
  parameter int SPLIT       = 0,
  parameter int DELAY_SIZE  = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                              intclk,
  input  logic                              reset,
  input  logic                              capture,
  input  logic                              step,
  input  logic [2*NUM_INPUTS-1:0]           mode_a,
  input  logic [WIDTH*NUM_INPUTS-1:0]       start_a,
  input  logic [WIDTH*NUM_INPUTS-1:0]       increment_a,
  input  logic [WIDTH*NUM_INPUTS-1:0]       len_a,
  output logic [WIDTH*NUM_INPUTS-1:0]       current_a,
  output logic [NUM_INPUTS-1:0]             done,
  output logic [NUM_INPUTS-1:0]             wrap_pulse,
  output logic                              all_done,
  output logic [COUNT_WIDTH*NUM_INPUTS-1:0] sweep_count_a
);

  logic capture_q;
  logic active;

  // The cycle capture rises is still a reload cycle, so a coincident step is dropped.
  always_ff @(posedge intclk or negedge reset) begin
    if (!reset) capture_q <= 1'b0;
    else        capture_q <= capture;
  end

  assign active = capture & capture_q;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    lag_scan_channel #(
      .WIDTH       (WIDTH),
      .FINE_BITS   (FINE_BITS),
      .SPLIT       (SPLIT),
      .DELAY_SIZE  (DELAY_SIZE),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_ch (
      .intclk_i      (intclk),
      .rst_ni        (reset),
      .active_i      (active),
      .step_i        (step),
      .mode_i        (mode_a[2*g +: 2]),
      .start_i       (start_a[WIDTH*g +: WIDTH]),
      .increment_i   (increment_a[WIDTH*g +: WIDTH]),
      .len_i         (len_a[WIDTH*g +: WIDTH]),
      .current_o     (current_a[WIDTH*g +: WIDTH]),
      .done_o        (done[g]),
      .wrap_pulse_o  (wrap_pulse[g]),
      .sweep_count_o (sweep_count_a[COUNT_WIDTH*g +: COUNT_WIDTH])
    );
  end

  logic any_single, every_done;

  always_comb begin
    any_single = 1'b0;
    every_done = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (mode_e'(mode_a[2*i +: 2]) == MODE_SINGLE) begin
        any_single = 1'b1;
        every_done = every_done & done[i];
      end
    end
    all_done = any_single & every_done;
  end

endmodule

// File: tb/tb_lag_scan_sequencer.sv
// Directed bench for lag_scan_sequencer: per-cycle model compare plus literal checkpoints.
module tb_lag_scan_sequencer;

  localparam int N  = 8;
  localparam int W  = 24;
  localparam int CW = 8;

  logic intclk = 1'b0;
  logic reset, capture, step;
  logic [1:0]   mode_v[N];
  logic [W-1:0] start_v[N], inc_v[N], len_v[N];

  logic [2*N-1:0]  mode_a;
  logic [W*N-1:0]  start_a, increment_a, len_a;
  logic [W*N-1:0]  current_a, current_s;
  logic [N-1:0]    done, wrap_pulse, done_s, wrap_s;
  logic            all_done, all_done_s;
  logic [CW*N-1:0] sweep_count_a, sweep_count_s;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 intclk = ~intclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mode_a[2*i +: 2]      = mode_v[i];
      start_a[W*i +: W]     = start_v[i];
      increment_a[W*i +: W] = inc_v[i];
      len_a[W*i +: W]       = len_v[i];
    end
  end

  lag_scan_sequencer dut (
    .intclk(intclk), .reset(reset), .capture(capture), .step(step),
    .mode_a(mode_a), .start_a(start_a), .increment_a(increment_a), .len_a(len_a),
    .current_a(current_a), .done(done), .wrap_pulse(wrap_pulse),
    .all_done(all_done), .sweep_count_a(sweep_count_a)
  );

  lag_scan_sequencer #(.SPLIT(1), .DELAY_SIZE(5)) dut_s (
    .intclk(intclk), .reset(reset), .capture(capture), .step(step),
    .mode_a(mode_a), .start_a(start_a), .increment_a(increment_a), .len_a(len_a),
    .current_a(current_s), .done(done_s), .wrap_pulse(wrap_s),
    .all_done(all_done_s), .sweep_count_a(sweep_count_s)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the linear (non-split) channels, in plain integers.
  longint m_cur[N];
  bit     m_done[N], m_pulse[N], m_up[N];
  int     m_cnt[N];
  bit     cap_prev;

  always @(posedge intclk or negedge reset) begin : model
    longint s, inc, ln, e, c;
    bit     ev, degen;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_cur[i] = 0; m_done[i] = 0; m_pulse[i] = 0; m_up[i] = 1; m_cnt[i] = 0;
      end
      cap_prev = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        s = start_v[i]; inc = inc_v[i]; ln = len_v[i]; e = s + ln; c = m_cur[i];
        ev = 0; degen = (inc == 0) || (ln == 0);
        m_pulse[i] = 0;
        if (!(capture && cap_prev)) begin
          m_cur[i] = s; m_done[i] = 0; m_up[i] = 1; m_cnt[i] = 0;
        end else if (step) begin
          case (mode_v[i])
            2'd1: if (!m_done[i]) begin
              if (!degen && c + inc <= e) m_cur[i] = c + inc;
              else begin m_done[i] = 1; ev = 1; end
            end
            2'd2: if (!degen && c + inc <= e) m_cur[i] = c + inc;
                  else begin m_cur[i] = s; ev = 1; end
            2'd3: if (degen) ev = 1;
                  else if (m_up[i]) begin
                    if (c + inc <= e) m_cur[i] = c + inc;
                    else begin m_up[i] = 0; m_cur[i] = (c - inc > s) ? c - inc : s; ev = 1; end
                  end else begin
                    if (c - inc >= s) m_cur[i] = c - inc;
                    else begin m_up[i] = 1; m_cur[i] = (c + inc < e) ? c + inc : e; ev = 1; end
                  end
            default: ;
          endcase
          if (ev) begin
            m_pulse[i] = 1;
            if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
          end
        end
      end
      cap_prev = capture;
    end
  end

  always @(negedge intclk) begin : compare
    logic [W*N-1:0]  e_cur;
    logic [CW*N-1:0] e_cnt;
    logic [N-1:0]    e_done, e_pulse;
    logic            any1, all1;
    if (cmp_en) begin
      any1 = 0; all1 = 1;
      for (int i = 0; i < N; i++) begin
        e_cur[W*i +: W]   = W'(m_cur[i]);
        e_cnt[CW*i +: CW] = CW'(m_cnt[i]);
        e_done[i]  = m_done[i];
        e_pulse[i] = m_pulse[i];
        if (mode_v[i] == 2'd1) begin any1 = 1; all1 = all1 & m_done[i]; end
      end
      check("model current_a", current_a, e_cur);
      check("model done", done, e_done);
      check("model wrap_pulse", wrap_pulse, e_pulse);
      check("model sweep_count_a", sweep_count_a, e_cnt);
      check("model all_done", all_done, any1 & all1);
    end
  end

  function automatic logic [W-1:0] cur(input int i);
    return current_a[W*i +: W];
  endfunction

  function automatic logic [CW-1:0] cnt(input int i);
    return sweep_count_a[CW*i +: CW];
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge intclk); #1; end
  endtask

  task automatic do_step();
    step = 1'b1;
    @(posedge intclk); #1;
    step = 1'b0;
  endtask

  task automatic set_ch(input int i, input logic [1:0] m, input int s, input int inc, input int ln);
    mode_v[i] = m; start_v[i] = W'(s); inc_v[i] = W'(inc); len_v[i] = W'(ln);
  endtask

  int  a_c0[5] = '{13, 16, 19, 19, 19};
  int  a_c1[5] = '{4, 8, 0, 4, 8};
  bit  a_p0[5] = '{0, 0, 0, 1, 0};
  bit  a_p1[5] = '{0, 0, 1, 0, 0};
  bit  a_ad[5] = '{0, 0, 0, 1, 1};
  int  b_c3[6] = '{7, 9, 7, 5, 7, 9};
  bit  b_p3[6] = '{0, 0, 1, 0, 1, 0};
  int  e_cs[3] = '{'h003, 'h1001, 'h1004};

  initial begin
    reset = 1'b0; capture = 1'b0; step = 1'b0;
    for (int i = 0; i < N; i++) set_ch(i, 2'd0, 50 + i, 1, 4);
    set_ch(0, 2'd1, 10, 3, 9);
    set_ch(1, 2'd2, 0, 4, 8);
    set_ch(2, 2'd0, 77, 5, 20);
    cycles(2);
    cmp_en = 1'b1;
    check("reset current_a", current_a, 0);
    check("reset done", done, 0);
    check("reset all_done", all_done, 0);
    reset = 1'b1;
    cycles(2);
    check("idle ch0 current", cur(0), 10);

    // Mixed channels; capture rises together with a step, which must not advance.
    capture = 1'b1; step = 1'b1;
    @(posedge intclk); #1;
    step = 1'b0;
    check("rise+step ch0 current", cur(0), 10);
    for (int k = 0; k < 5; k++) begin
      do_step();
      check("A ch0 current", cur(0), a_c0[k]);
      check("A ch1 current", cur(1), a_c1[k]);
      check("A ch0 pulse", wrap_pulse[0], a_p0[k]);
      check("A ch1 pulse", wrap_pulse[1], a_p1[k]);
      check("A all_done", all_done, a_ad[k]);
      check("A ch2 current", cur(2), 77);
    end
    check("A ch0 done", done[0], 1);
    check("A ch0 count", cnt(0), 1);
    check("A ch1 count", cnt(1), 1);

    // capture drops with a step pending: reload, step ignored.
    capture = 1'b0; step = 1'b1;
    @(posedge intclk); #1;
    step = 1'b0;
    check("drop ch1 current", cur(1), 0);
    check("drop ch1 count", cnt(1), 0);
    check("drop ch0 done", done[0], 0);

    // Ping-pong plus degenerate increment/len channels.
    set_ch(3, 2'd3, 5, 2, 4);
    set_ch(4, 2'd1, 20, 0, 5);
    set_ch(5, 2'd2, 30, 3, 0);
    set_ch(6, 2'd3, 40, 0, 8);
    cycles(2);
    capture = 1'b1;
    cycles(1);
    for (int k = 0; k < 6; k++) begin
      do_step();
      check("B ch3 current", cur(3), b_c3[k]);
      check("B ch3 pulse", wrap_pulse[3], b_p3[k]);
      check("B ch4 pulse", wrap_pulse[4], k == 0);
      check("B ch5 pulse", wrap_pulse[5], 1);
      check("B ch5 current", cur(5), 30);
      check("B ch6 current", cur(6), 40);
    end
    check("B ch3 count", cnt(3), 2);
    check("B ch4 done", done[4], 1);
    check("B ch6 count", cnt(6), 6);

    // Mode changes mid-sweep keep current and direction.
    capture = 1'b0;
    set_ch(7, 2'd0, 100, 10, 30);
    cycles(2);
    capture = 1'b1;
    cycles(1);
    mode_v[7] = 2'd2;
    do_step(); do_step();
    check("C ch7 wrap phase", cur(7), 120);
    mode_v[7] = 2'd3;
    do_step(); do_step();
    check("C ch7 pingpong turn", cur(7), 120);
    check("C ch7 turn pulse", wrap_pulse[7], 1);
    mode_v[7] = 2'd1;
    do_step();
    check("C ch7 single from down", cur(7), 130);
    do_step();
    check("C ch7 done", done[7], 1);

    // Sweep counter saturation on an always-ending channel.
    repeat (260) do_step();
    check("D ch5 count saturated", cnt(5), 255);

    // Coarse/fine instance.
    capture = 1'b0;
    set_ch(0, 2'd2, 0, 3, 'h3000);
    cycles(2);
    capture = 1'b1;
    cycles(1);
    for (int k = 0; k < 3; k++) begin
      do_step();
      check("E split ch0 current", current_s[W-1:0], e_cs[k]);
    end

    // Asynchronous reset in the middle of a sweep.
    do_step(); do_step();
    #2 reset = 1'b0;
    #1;
    check("F reset current_a", current_a, 0);
    check("F reset split current", current_s, 0);
    check("F reset sweep_count_a", sweep_count_a, 0);
    check("F reset done", done, 0);
    check("F reset wrap_pulse", wrap_pulse, 0);
    check("F reset all_done", all_done, 0);
    cycles(3);
    reset = 1'b1;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
